axis_tdest_mux: RTL and testbench

- Merges three upstream AXI-Stream sources, RX2/RX3/RX4, into one AXI-Stream output.
- Arbitrates per packet, round-robin: once a source is granted, the grant is held until its tlast beat is accepted.
- Each output beat is tagged with tdest = source index (RX2→0, RX3→1, RX4→2), so the downstream tdest demultiplexer in the Scheduler path can split the stream again.
- Output is registered. It sits between the per-port FIFOs and the shared processing stream.

---
 rtl/axis_tdest_mux_pkg.sv | 21 ++
 rtl/axis_rr_arbiter.sv | 51 +++++
 rtl/axis_tdest_mux.sv | 168 ++++++++++++++++
 tb/tb_axis_tdest_mux.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_tdest_mux_pkg.sv
// Shared scheduler constants: source indices, source count and mux state encoding.
// The tdest demultiplexer downstream uses the same source index values.
package axis_tdest_mux_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_TX2 = 2'd0;
  localparam logic [1:0] SRC_TX3 = 2'd1;
  localparam logic [1:0] SRC_TX4 = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mux_state_e;

  // Next source index in rotating order, wrapping after the last source.
  function automatic logic [1:0] nextSrc(input logic [1:0] idx);
    return (idx == SRC_TX4) ? SRC_TX2 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Three-way rotating-priority arbiter. The search starts one past the most
// recent grant, so a source that was just served drops to lowest priority.
module axis_rr_arbiter
  import axis_tdest_mux_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               advance_i,
  output logic [1:0]         grant_o,
  output logic               anyReq_o
);

  logic [1:0] lastGrant_q, lastGrant_d;
  logic [1:0] cand1, cand2, cand3;

  assign cand1    = nextSrc(lastGrant_q);
  assign cand2    = nextSrc(cand1);
  assign cand3    = lastGrant_q;
  assign anyReq_o = |req_i;

  // Pick the first requester in rotating order starting after the last grant.
  always_comb begin
    grant_o = cand1;
    if (req_i[cand1]) begin
      grant_o = cand1;
    end else if (req_i[cand2]) begin
      grant_o = cand2;
    end else if (req_i[cand3]) begin
      grant_o = cand3;
    end
  end

  // Remember the grant only when the mux actually commits to it.
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (advance_i) begin
      lastGrant_d = grant_o;
    end
  end

  // Reset to the last source so the first source has priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q <= SRC_TX4;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/axis_tdest_mux.sv
// Packet-atomic round-robin merge of RX2/RX3/RX4 onto one registered
// AXI-Stream output. Each beat carries its source index on tdest.
module axis_tdest_mux
  import axis_tdest_mux_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_RX2_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_RX2_tkeep,
  input  logic                       s_axis_RX2_tvalid,
  output logic                       s_axis_RX2_tready,
  input  logic                       s_axis_RX2_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_RX3_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_RX3_tkeep,
  input  logic                       s_axis_RX3_tvalid,
  output logic                       s_axis_RX3_tready,
  input  logic                       s_axis_RX3_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_RX4_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_RX4_tkeep,
  input  logic                       s_axis_RX4_tvalid,
  output logic                       s_axis_RX4_tready,
  input  logic                       s_axis_RX4_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_mux_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_mux_tkeep,
  output logic                       m_axis_mux_tvalid,
  input  logic                       m_axis_mux_tready,
  output logic                       m_axis_mux_tlast,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_mux_tdest
);

  mux_state_e                 state_q, state_d;
  logic [1:0]                 grant_q, grant_d;
  logic [1:0]                 arbGrant;
  logic                       anyReq;
  logic                       advance;
  logic [NUM_SRC-1:0]         srcValid;

  logic [AXIS_DATA_WIDTH-1:0] selData;
  logic [AXIS_KEEP_WIDTH-1:0] selKeep;
  logic [AXIS_DEST_WIDTH-1:0] selDest;
  logic                       selValid;
  logic                       selLast;
  logic                       srcReady;
  logic                       accept;

  logic [AXIS_DATA_WIDTH-1:0] outData_q;
  logic [AXIS_KEEP_WIDTH-1:0] outKeep_q;
  logic [AXIS_DEST_WIDTH-1:0] outDest_q;
  logic                       outValid_q;
  logic                       outLast_q;

  assign srcValid = {s_axis_RX4_tvalid, s_axis_RX3_tvalid, s_axis_RX2_tvalid};

  axis_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (srcValid),
    .advance_i (advance),
    .grant_o   (arbGrant),
    .anyReq_o  (anyReq)
  );

  // Route the granted source's beat toward the output register.
  always_comb begin
    selData  = '0;
    selKeep  = '0;
    selValid = 1'b0;
    selLast  = 1'b0;
    selDest  = '0;
    selDest[1:0] = grant_q;
    case (grant_q)
      SRC_TX2: begin
        selData  = s_axis_RX2_tdata;
        selKeep  = s_axis_RX2_tkeep;
        selValid = s_axis_RX2_tvalid;
        selLast  = s_axis_RX2_tlast;
      end
      SRC_TX3: begin
        selData  = s_axis_RX3_tdata;
        selKeep  = s_axis_RX3_tkeep;
        selValid = s_axis_RX3_tvalid;
        selLast  = s_axis_RX3_tlast;
      end
      SRC_TX4: begin
        selData  = s_axis_RX4_tdata;
        selKeep  = s_axis_RX4_tkeep;
        selValid = s_axis_RX4_tvalid;
        selLast  = s_axis_RX4_tlast;
      end
      default: begin
        selValid = 1'b0;
      end
    endcase
  end

  // The granted source may push whenever the output register is empty or draining.
  assign srcReady = (state_q == BUSY) && (!outValid_q || m_axis_mux_tready);
  assign accept   = srcReady && selValid;

  assign s_axis_RX2_tready = srcReady && (grant_q == SRC_TX2);
  assign s_axis_RX3_tready = srcReady && (grant_q == SRC_TX3);
  assign s_axis_RX4_tready = srcReady && (grant_q == SRC_TX4);

  // Arbitrate in IDLE, then hold the grant until the packet's tlast is accepted.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          grant_d = arbGrant;
          advance = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && selLast) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= SRC_TX2;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Output register: load on accept, otherwise hold until the consumer drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData_q  <= '0;
      outKeep_q  <= '0;
      outDest_q  <= '0;
      outLast_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else if (accept) begin
      outData_q  <= selData;
      outKeep_q  <= selKeep;
      outDest_q  <= selDest;
      outLast_q  <= selLast;
      outValid_q <= 1'b1;
    end else if (m_axis_mux_tready) begin
      outValid_q <= 1'b0;
    end
  end

  assign m_axis_mux_tdata  = outData_q;
  assign m_axis_mux_tkeep  = outKeep_q;
  assign m_axis_mux_tdest  = outDest_q;
  assign m_axis_mux_tlast  = outLast_q;
  assign m_axis_mux_tvalid = outValid_q;

endmodule

// File: tb/tb_axis_tdest_mux.sv
// Testbench for axis_tdest_mux: per-source drivers, a spec-level reference
// model of arbitration and the output register, and per-source scoreboards.
`timescale 1ns/1ps
module tb_axis_tdest_mux;

  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            gap;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] sData [3] = '{64'h0, 64'h0, 64'h0};
  logic [KW-1:0] sKeep [3] = '{8'h0, 8'h0, 8'h0};
  logic          sValid[3] = '{1'b0, 1'b0, 1'b0};
  logic          sLast [3] = '{1'b0, 1'b0, 1'b0};
  logic          sReady[3];
  logic [DW-1:0] mData;
  logic [KW-1:0] mKeep;
  logic          mValid;
  logic          mReady = 1'b1;
  logic          mLast;
  logic [1:0]    mDest;

  beat_t stimQ[3][$];
  beat_t expQ [3][$];
  int    pktOrder[$];
  int    obsOrder[$];

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state
  logic          mBusy = 1'b0;
  int            mGrant = 0;
  int            lastG = 2;
  logic          mOutValid = 1'b0;
  logic [DW-1:0] mOutData = '0;
  logic [KW-1:0] mOutKeep = '0;
  logic          mOutLast = 1'b0;
  int            mOutDest = 0;
  logic          inPkt = 1'b0;

  logic [DW-1:0] lastSeenData = '0;
  logic [KW-1:0] lastSeenKeep = '0;
  logic          lastSeenLast = 1'b0;
  logic [1:0]    lastSeenDest = '0;

  always #5 clk = ~clk;

  axis_tdest_mux #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(KW),
    .AXIS_DEST_WIDTH(2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_RX2_tdata  (sData[0]),
    .s_axis_RX2_tkeep  (sKeep[0]),
    .s_axis_RX2_tvalid (sValid[0]),
    .s_axis_RX2_tready (sReady[0]),
    .s_axis_RX2_tlast  (sLast[0]),
    .s_axis_RX3_tdata  (sData[1]),
    .s_axis_RX3_tkeep  (sKeep[1]),
    .s_axis_RX3_tvalid (sValid[1]),
    .s_axis_RX3_tready (sReady[1]),
    .s_axis_RX3_tlast  (sLast[1]),
    .s_axis_RX4_tdata  (sData[2]),
    .s_axis_RX4_tkeep  (sKeep[2]),
    .s_axis_RX4_tvalid (sValid[2]),
    .s_axis_RX4_tready (sReady[2]),
    .s_axis_RX4_tlast  (sLast[2]),
    .m_axis_mux_tdata  (mData),
    .m_axis_mux_tkeep  (mKeep),
    .m_axis_mux_tvalid (mValid),
    .m_axis_mux_tready (mReady),
    .m_axis_mux_tlast  (mLast),
    .m_axis_mux_tdest  (mDest)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one packet for a source; the same beats become that source's expected output.
  task automatic applyStimulus(input int src, input int len, input logic [DW-1:0] base,
                               input logic [DW-1:0] step, input logic [KW-1:0] lastKeep,
                               input int gapBeat, input int gapLen);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = base + step * 64'(k);
      b.keep = (k == len - 1) ? lastKeep : 8'hFF;
      b.last = (k == len - 1);
      b.gap  = (k == gapBeat) ? gapLen : 0;
      stimQ[src].push_back(b);
      expQ[src].push_back(b);
    end
  endtask

  task automatic driveSource(input int idx);
    beat_t b;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || stimQ[idx].size() == 0) begin
        sValid[idx] = 1'b0;
      end else begin
        b = stimQ[idx].pop_front();
        sValid[idx] = 1'b0;
        repeat (b.gap) begin
          @(posedge clk);
          #1;
        end
        sData[idx]  = b.data;
        sKeep[idx]  = b.keep;
        sLast[idx]  = b.last;
        sValid[idx] = 1'b1;
        do begin
          @(negedge clk);
        end while (rst_n && !sReady[idx]);
        if (!rst_n) begin
          stimQ[idx].delete();
        end
      end
    end
  endtask

  initial driveSource(0);
  initial driveSource(1);
  initial driveSource(2);

  // Monitor: reference model of grant rules and output register, plus scoreboards.
  initial begin : monitor
    logic [2:0]    expRdy;
    logic [2:0]    actRdy;
    logic          acc;
    int            g;
    int            c;
    int            d;
    beat_t         eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mBusy = 1'b0;
        mGrant = 0;
        lastG = 2;
        mOutValid = 1'b0;
        inPkt = 1'b0;
        for (int s = 0; s < 3; s++) expQ[s].delete();
        pktOrder.delete();
      end else begin
        expRdy = 3'b000;
        if (mBusy) expRdy[mGrant] = !mOutValid || mReady;
        actRdy = {sReady[2], sReady[1], sReady[0]};
        checkOutput("s_tready vector", 64'(actRdy), 64'(expRdy));
        checkOutput("m_tvalid", 64'(mValid), 64'(mOutValid));
        if (mOutValid) begin
          checkOutput("m_tdata", mData, mOutData);
          checkOutput("m_tkeep", 64'(mKeep), 64'(mOutKeep));
          checkOutput("m_tlast", 64'(mLast), 64'(mOutLast));
          checkOutput("m_tdest", 64'(mDest), 64'(mOutDest));
        end
        if (mValid && mReady) begin
          lastSeenData = mData;
          lastSeenKeep = mKeep;
          lastSeenLast = mLast;
          lastSeenDest = mDest;
          d = int'(mDest);
          checkOutput("tdest in range", 64'(d < 3), 64'd1);
          if (!inPkt) begin
            obsOrder.push_back(d);
            checkOutput("grant queue nonempty", 64'(pktOrder.size() != 0), 64'd1);
            if (pktOrder.size() != 0) checkOutput("packet grant order", 64'(d), 64'(pktOrder.pop_front()));
          end
          if (d < 3) begin
            checkOutput("scoreboard nonempty", 64'(expQ[d].size() != 0), 64'd1);
            if (expQ[d].size() != 0) begin
              eb = expQ[d].pop_front();
              checkOutput("sb data", mData, eb.data);
              checkOutput("sb keep", 64'(mKeep), 64'(eb.keep));
              checkOutput("sb last", 64'(mLast), 64'(eb.last));
            end
          end
          inPkt = !mLast;
        end
        acc = mBusy && sValid[mGrant] && (!mOutValid || mReady);
        if (acc) begin
          mOutValid = 1'b1;
          mOutData  = sData[mGrant];
          mOutKeep  = sKeep[mGrant];
          mOutLast  = sLast[mGrant];
          mOutDest  = mGrant;
        end else if (mReady) begin
          mOutValid = 1'b0;
        end
        if (!mBusy) begin
          g = -1;
          for (int k = 1; k <= 3; k++) begin
            c = (lastG + k) % 3;
            if (sValid[c] && g < 0) g = c;
          end
          if (g >= 0) begin
            mBusy = 1'b1;
            mGrant = g;
            lastG = g;
            pktOrder.push_back(g);
          end
        end else if (acc && sLast[mGrant]) begin
          mBusy = 1'b0;
        end
      end
    end
  end

  task automatic waitIdle(input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #3;
      if (stimQ[0].size() == 0 && stimQ[1].size() == 0 && stimQ[2].size() == 0 &&
          expQ[0].size() == 0 && expQ[1].size() == 0 && expQ[2].size() == 0 &&
          !sValid[0] && !sValid[1] && !sValid[2] && !mOutValid && !mBusy) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(name, 64'(done), 64'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : control
    int   rrExp[6];
    logic found;
    logic [3:0] pat;
    rrExp = '{0, 1, 2, 0, 1, 2};

    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset m_tvalid", 64'(mValid), 64'd0);
    checkOutput("reset m_tdata", mData, 64'd0);
    checkOutput("reset m_tkeep", 64'(mKeep), 64'd0);
    checkOutput("reset m_tlast", 64'(mLast), 64'd0);
    checkOutput("reset m_tdest", 64'(mDest), 64'd0);
    checkOutput("reset treadies", 64'({sReady[2], sReady[1], sReady[0]}), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] round-robin with all sources saturated");
    @(posedge clk);
    #2;
    obsOrder.delete();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 3; s++)
        applyStimulus(s, 2, 64'h1000 * 64'(s + 1) + 64'h100 * 64'(p), 64'h1, 8'hFF, -1, 0);
    waitIdle(200, "rr drain");
    checkOutput("rr packet count", 64'(obsOrder.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      checkOutput("rr order", (i < obsOrder.size()) ? 64'(obsOrder[i]) : 64'd99, 64'(rrExp[i]));

    $display("[TB] single RX3 packet with partial last keep");
    @(posedge clk);
    #2;
    applyStimulus(1, 3, 64'h11, 64'h11, 8'h0F, -1, 0);
    waitIdle(100, "single drain");
    checkOutput("single last data", lastSeenData, 64'h33);
    checkOutput("single last keep", 64'(lastSeenKeep), 64'h0F);
    checkOutput("single last tlast", 64'(lastSeenLast), 64'd1);
    checkOutput("single tdest", 64'(lastSeenDest), 64'd1);

    $display("[TB] backpressure on RX2 stream");
    @(posedge clk);
    #2;
    pat = 4'b1001;
    applyStimulus(0, 4, 64'hA0, 64'h1, 8'hFF, -1, 0);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      mReady = pat[3 - (c % 4)];
    end
    @(posedge clk);
    #1 mReady = 1'b1;
    waitIdle(100, "backpressure drain");

    $display("[TB] grant lock while RX4 pauses mid-packet");
    @(posedge clk);
    #2;
    obsOrder.delete();
    applyStimulus(2, 4, 64'hC0, 64'h1, 8'hFF, 2, 3);
    repeat (3) @(posedge clk);
    #2;
    applyStimulus(0, 2, 64'hD0, 64'h1, 8'hFF, -1, 0);
    waitIdle(100, "grant lock drain");
    checkOutput("lock packet count", 64'(obsOrder.size()), 64'd2);
    checkOutput("lock first grant", (obsOrder.size() > 0) ? 64'(obsOrder[0]) : 64'd99, 64'd2);
    checkOutput("lock second grant", (obsOrder.size() > 1) ? 64'(obsOrder[1]) : 64'd99, 64'd0);

    $display("[TB] reset in the middle of an RX3 packet");
    @(posedge clk);
    #2;
    applyStimulus(1, 3, 64'hB1, 64'h1, 8'hFF, -1, 0);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (sValid[1] && sReady[1] && sData[1] == 64'hB2) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("second RX3 beat accepted", 64'(found), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid reset m_tvalid", 64'(mValid), 64'd0);
    checkOutput("mid reset treadies", 64'({sReady[2], sReady[1], sReady[0]}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    obsOrder.delete();
    for (int s = 0; s < 3; s++) applyStimulus(s, 1, 64'hE0 + 64'(s), 64'h1, 8'hFF, -1, 0);
    waitIdle(100, "post reset drain");
    checkOutput("post reset first grant", (obsOrder.size() > 0) ? 64'(obsOrder[0]) : 64'd99, 64'd0);

    $display("[TB] randomized traffic with random backpressure");
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #2;
      mReady = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < 3; s++) begin
        if (stimQ[s].size() == 0 && $urandom_range(0, 2) == 0)
          applyStimulus(s, int'($urandom_range(1, 4)), {$urandom, $urandom}, 64'($urandom),
                        8'($urandom_range(1, 255)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 2)));
      end
    end
    @(posedge clk);
    #2 mReady = 1'b1;
    waitIdle(2000, "random drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
